// File: rtl/shear_sort_pkg.sv
// Shared encodings and sizing helpers for the shear-sort mesh sequencer.
// Phase count covers ceil(log2 ROWS) row+column pairs plus the closing row phase.
package shear_sort_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic AXIS_ROW = 1'b0;
  localparam logic AXIS_COL = 1'b1;
  localparam logic DIR_ASC  = 1'b0;
  localparam logic DIR_DESC = 1'b1;

  function automatic int num_phases(input int rows);
    return 2 * $clog2(rows) + 1;
  endfunction

  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mesh_step_timer.sv
// Step and sub-cycle counters for one odd-even transposition phase; frozen while adv_i is low.
// last_sub_o marks the final sub-cycle of a step, last_step_o the final sub-cycle of the phase.
module mesh_step_timer
  import shear_sort_pkg::*;
#(
  parameter int STEP_W      = 2,
  parameter int STEP_CYCLES = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              adv_i,
  input  logic [STEP_W-1:0] last_step_idx_i,
  output logic              last_sub_o,
  output logic              last_step_o
);

  localparam int SUB_W = cnt_width(STEP_CYCLES);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(STEP_CYCLES - 1);

  logic [STEP_W-1:0] step_q, step_d;
  logic [SUB_W-1:0]  sub_q, sub_d;

  assign last_sub_o  = (sub_q == SUB_LAST);
  assign last_step_o = last_sub_o && (step_q == last_step_idx_i);

  always_comb begin
    step_d = step_q;
    sub_d  = sub_q;
    if (clr_i) begin
      step_d = '0;
      sub_d  = '0;
    end else if (adv_i) begin
      if (last_sub_o) begin
        sub_d  = '0;
        step_d = last_step_o ? '0 : step_q + STEP_W'(1);
      end else begin
        sub_d = sub_q + SUB_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      step_q <= '0;
      sub_q  <= '0;
    end else begin
      step_q <= step_d;
      sub_q  <= sub_d;
    end
  end

endmodule

// File: rtl/shear_sort_ctrl.sv
// Shear-sort sequencer: load, then alternating row/column phases, then a final row phase.
// Outputs are registered one cycle ahead; hold masks the strobes and freezes all state.
module shear_sort_ctrl
  import shear_sort_pkg::*;
#(
  parameter int ROWS        = 4,
  parameter int COLS        = 4,
  parameter int STEP_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            hold,
  output logic            load_en,
  output logic            pe_en,
  output logic            axis,
  output logic            pair_parity,
  output logic [ROWS-1:0] dir_mask,
  output logic            busy,
  output logic            done
);

  localparam int NUM_PH = num_phases(ROWS);
  localparam int PH_W   = cnt_width(NUM_PH);
  localparam int MAX_N  = (ROWS > COLS) ? ROWS : COLS;
  localparam int STEP_W = cnt_width(MAX_N);

  localparam logic [STEP_W-1:0] ROW_LAST = STEP_W'(COLS - 1);
  localparam logic [STEP_W-1:0] COL_LAST = STEP_W'(ROWS - 1);
  localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(NUM_PH - 1);

  state_e          state_q;
  logic [PH_W-1:0] phase_q;
  logic            load_en_q, pe_en_q, axis_q, parity_q, busy_q, done_q;
  logic [ROWS-1:0] dir_q;
  logic [ROWS-1:0] row_dir;

  logic            tmr_clr, tmr_adv, last_sub, last_step, last_phase;
  logic [STEP_W-1:0] last_step_idx;

  // Snake order: odd rows sort descending so the sorted sequence reads boustrophedon.
  always_comb begin
    row_dir = '0;
    for (int r = 0; r < ROWS; r++) begin
      row_dir[r] = (r % 2 == 1) ? DIR_DESC : DIR_ASC;
    end
  end

  assign tmr_clr       = (state_q == ST_LOAD) && !hold;
  assign tmr_adv       = (state_q == ST_RUN) && !hold;
  assign last_step_idx = (axis_q == AXIS_COL) ? COL_LAST : ROW_LAST;
  assign last_phase    = (phase_q == PH_LAST);

  mesh_step_timer #(
    .STEP_W      (STEP_W),
    .STEP_CYCLES (STEP_CYCLES)
  ) u_timer (
    .clk_i           (clk),
    .rst_i           (reset),
    .clr_i           (tmr_clr),
    .adv_i           (tmr_adv),
    .last_step_idx_i (last_step_idx),
    .last_sub_o      (last_sub),
    .last_step_o     (last_step)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      phase_q   <= '0;
      load_en_q <= 1'b0;
      pe_en_q   <= 1'b0;
      axis_q    <= AXIS_ROW;
      parity_q  <= 1'b0;
      dir_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else if (!hold) begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q   <= ST_LOAD;
            load_en_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        ST_LOAD: begin
          state_q   <= ST_RUN;
          load_en_q <= 1'b0;
          phase_q   <= '0;
          pe_en_q   <= 1'b1;
          axis_q    <= AXIS_ROW;
          parity_q  <= 1'b0;
          dir_q     <= row_dir;
        end
        ST_RUN: begin
          // The next cycle opens a new step unless this is the very last sub-cycle of the sort.
          pe_en_q <= last_sub && !(last_step && last_phase);
          if (last_step) begin
            parity_q <= 1'b0;
            if (last_phase) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              axis_q  <= AXIS_ROW;
              dir_q   <= '0;
            end else begin
              phase_q <= phase_q + PH_W'(1);
              axis_q  <= ~axis_q;
              dir_q   <= (axis_q == AXIS_COL) ? row_dir : '0;
            end
          end else if (last_sub) begin
            parity_q <= ~parity_q;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign load_en     = load_en_q & ~hold;
  assign pe_en       = pe_en_q & ~hold;
  assign done        = done_q & ~hold;
  assign axis        = axis_q;
  assign pair_parity = parity_q;
  assign dir_mask    = dir_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_shear_sort_ctrl.sv
// Bench for shear_sort_ctrl: 4x4 and 1x4 instances against a slot-queue model of the schedule.
// Each unheld cycle consumes one expected slot; a held cycle shows the slot with strobes masked.
module tb_shear_sort_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic start0 = 1'b0, hold0 = 1'b0, start1 = 1'b0, hold1 = 1'b0;
  logic ld0, pe0, ax0, par0, bs0, dn0;
  logic [3:0] dir0;
  logic ld1, pe1, ax1, par1, bs1, dn1;
  logic [0:0] dir1;

  shear_sort_ctrl #(.ROWS(4), .COLS(4), .STEP_CYCLES(2)) dut (
    .clk(clk), .reset(reset), .start(start0), .hold(hold0),
    .load_en(ld0), .pe_en(pe0), .axis(ax0), .pair_parity(par0),
    .dir_mask(dir0), .busy(bs0), .done(dn0)
  );

  shear_sort_ctrl #(.ROWS(1), .COLS(4), .STEP_CYCLES(2)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .hold(hold1),
    .load_en(ld1), .pe_en(pe1), .axis(ax1), .pair_parity(par1),
    .dir_mask(dir1), .busy(bs1), .done(dn1)
  );

  typedef struct packed {
    logic       bs;
    logic       dn;
    logic       ld;
    logic       pe;
    logic       ax;
    logic       par;
    logic [3:0] dir;
  } slot_t;

  slot_t act0, act1;
  assign act0 = {bs0, dn0, ld0, pe0, ax0, par0, dir0};
  assign act1 = {bs1, dn1, ld1, pe1, ax1, par1, 3'b000, dir1};

  int    vectors = 0;
  int    miscompares = 0;
  slot_t q[$];

  function automatic int clog2i(input int n);
    int k = 0;
    while ((1 << k) < n) k++;
    return k;
  endfunction

  // Expected schedule for one sort: LOAD, every (phase, step, sub) cycle, DONE.
  task automatic build(input int rows, input int cols, input int sc);
    slot_t s;
    logic [3:0] rmask;
    int nph, n;
    bit col;
    rmask = '0;
    for (int r = 0; r < rows; r++) rmask[r] = (r % 2 == 1);
    s = '0; s.bs = 1'b1; s.ld = 1'b1; q.push_back(s);
    nph = 2 * clog2i(rows) + 1;
    for (int p = 0; p < nph; p++) begin
      col = (p % 2 == 1);
      n = col ? rows : cols;
      for (int st = 0; st < n; st++) begin
        for (int c = 0; c < sc; c++) begin
          s = '0;
          s.bs  = 1'b1;
          s.pe  = (c == 0);
          s.ax  = col;
          s.par = (st % 2 == 1);
          s.dir = col ? 4'b0000 : rmask;
          q.push_back(s);
        end
      end
    end
    s = '0; s.bs = 1'b1; s.dn = 1'b1; q.push_back(s);
  endtask

  task automatic set_in(input int sel, input logic st, input logic h);
    if (sel == 1) begin start1 = st; hold1 = h; end
    else begin start0 = st; hold0 = h; end
  endtask

  // Called and returns at a sample point (#1 after a rising edge) with the DUT idle.
  task automatic run_sort(input int sel, input int hold_pct, input int hold_at, input int hold_len,
                          input bit restart, output int done_cyc, output int pe_cnt, output int load_cyc);
    slot_t e, a, z;
    bit h;
    logic st;
    int c;
    z = '0;
    q.delete();
    build(sel == 1 ? 1 : 4, 4, 2);
    if (restart) begin q.push_back(z); build(sel == 1 ? 1 : 4, 4, 2); end
    done_cyc = -1; pe_cnt = 0; load_cyc = -1;
    st = restart;
    set_in(sel, 1'b1, 1'b0);
    @(posedge clk); #1;
    c = 1;
    while (q.size() > 0 && c < 400) begin
      h = (c >= hold_at && c < hold_at + hold_len) || ($urandom_range(99) < hold_pct);
      set_in(sel, st, h);
      #1;
      e = q[0];
      if (h) begin e.ld = 1'b0; e.pe = 1'b0; e.dn = 1'b0; end
      a = (sel == 1) ? act1 : act0;
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL schedule sel=%0d cycle=%0d hold=%0b got=%b want=%b", sel, c, h, a, e);
      end
      if (a.pe) pe_cnt++;
      if (a.dn && done_cyc < 0) done_cyc = c;
      if (a.ld) load_cyc = c;
      if (!h) begin
        if (e.ld && done_cyc > 0) st = 1'b0;
        void'(q.pop_front());
      end
      @(posedge clk); #1;
      c++;
    end
    set_in(sel, 1'b0, 1'b0);
    if (q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout sel=%0d left=%0d slots unconsumed, want 0", sel, q.size());
    end
  endtask

  task automatic check_idle(input int sel, input string name);
    slot_t a;
    set_in(sel, 1'b0, 1'b0);
    #1;
    a = (sel == 1) ? act1 : act0;
    vectors++;
    if (a !== slot_t'(0)) begin
      miscompares++;
      $display("FAIL %s got=%b want=0", name, a);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_int(input string name, input int got, input int want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    #2;
    vectors += 2;
    if (act0 !== slot_t'(0)) begin miscompares++; $display("FAIL reset0 got=%b want=0", act0); end
    if (act1 !== slot_t'(0)) begin miscompares++; $display("FAIL reset1 got=%b want=0", act1); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check_idle(0, "idle_after_reset0");
    check_idle(1, "idle_after_reset1");
  endtask

  task automatic test_basic();
    int d, p, l;
    run_sort(0, 0, 0, 0, 1'b0, d, p, l);
    check_int("basic_done_cycle", d, 42);
    check_int("basic_pe_count", p, 20);
    check_int("basic_load_cycle", l, 1);
    check_idle(0, "basic_idle_after");
  endtask

  task automatic test_hold();
    int d, p, l;
    run_sort(0, 0, 10, 3, 1'b0, d, p, l);
    check_int("hold_done_cycle", d, 45);
    check_int("hold_pe_count", p, 20);
  endtask

  task automatic test_hold_idle();
    slot_t a;
    for (int i = 0; i < 3; i++) begin
      set_in(0, 1'b1, 1'b1);
      #1;
      a = act0;
      vectors++;
      if (a !== slot_t'(0)) begin
        miscompares++;
        $display("FAIL hold_blocks_start cycle=%0d got=%b want=0", i, a);
      end
      @(posedge clk); #1;
    end
    check_idle(0, "hold_idle_release");
  endtask

  task automatic test_back_to_back();
    int d, p, l;
    run_sort(0, 0, 0, 0, 1'b1, d, p, l);
    check_int("b2b_first_done", d, 42);
    check_int("b2b_second_load", l, 44);
    check_int("b2b_pe_count", p, 40);
    check_idle(0, "b2b_idle_after");
  endtask

  task automatic test_reset_midrun();
    int d, p, l;
    set_in(0, 1'b1, 1'b0);
    @(posedge clk); #1;
    set_in(0, 1'b0, 1'b0);
    repeat (15) @(posedge clk);
    #1;
    #1;
    check_int("midrun_pe_step7", int'(pe0), 1);
    reset = 1'b1;
    #1;
    vectors++;
    if (act0 !== slot_t'(0)) begin
      miscompares++;
      $display("FAIL midrun_reset_outputs got=%b want=0", act0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    run_sort(0, 0, 0, 0, 1'b0, d, p, l);
    check_int("post_reset_done_cycle", d, 42);
    check_int("post_reset_pe_count", p, 20);
  endtask

  task automatic test_random_hold();
    int d, p, l;
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 3)) check_idle(0, "random_gap");
      run_sort(0, 25, 0, 0, 1'b0, d, p, l);
      check_int("random_pe_count", p, 20);
    end
    run_sort(1, 30, 0, 0, 1'b0, d, p, l);
    check_int("random_rows1_pe_count", p, 4);
  endtask

  task automatic test_rows1();
    int d, p, l;
    run_sort(1, 0, 0, 0, 1'b0, d, p, l);
    check_int("rows1_done_cycle", d, 10);
    check_int("rows1_pe_count", p, 4);
    check_idle(1, "rows1_idle_after");
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_hold_idle();
    test_back_to_back();
    test_reset_midrun();
    test_rows1();
    test_random_hold();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
